// File: rtl/inta_sequencer_if.sv
// CPU/cascade-facing acknowledge and data-bus bundle of the PIC
// priority and acknowledge stage.
interface inta_sequencer_if;
    logic       INTA_n;
    logic       Address_Write_Enable;
    logic       INT;
    logic [2:0] Interrupt_Location;
    logic       interruptExists;
    logic [7:0] Data_Out;
    logic       Data_Out_En;

    modport master (
        output INTA_n,
        output Address_Write_Enable,
        input  INT,
        input  Interrupt_Location,
        input  interruptExists,
        input  Data_Out,
        input  Data_Out_En
    );

    modport slave (
        input  INTA_n,
        input  Address_Write_Enable,
        output INT,
        output Interrupt_Location,
        output interruptExists,
        output Data_Out,
        output Data_Out_En
    );
endinterface

// File: rtl/inta_sequencer.sv
// 8259-style priority resolver and two-pulse 8086 INTA sequencer
// with ISR bookkeeping, EOI/AEOI handling and vector drive.
module inta_sequencer #(
    parameter int         NUM_IR       = 8,
    parameter logic [2:0] SPURIOUS_LOC = 3'd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] IRR,
    input  logic [NUM_IR-1:0] IMR,
    input  logic [7:0]        ICW2,
    input  logic              AEOI,
    input  logic              EOI_Strobe,
    input  logic              EOI_Specific,
    input  logic [2:0]        EOI_Level,
    output logic [NUM_IR-1:0] IRR_Clear,
    output logic [NUM_IR-1:0] ISR,
    inta_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2,
        DRIVE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              inta_d;
    logic              fall;
    logic              rise;
    logic [NUM_IR-1:0] req;
    logic [2:0]        cand;
    logic [2:0]        isr_low;
    logic              valid;
    logic              int_q;
    logic              int_d;
    logic [2:0]        loc_q;
    logic [2:0]        loc_d;
    logic              exists_q;
    logic              exists_d;
    logic [NUM_IR-1:0] isr_q;
    logic [NUM_IR-1:0] isr_d;
    logic [NUM_IR-1:0] irr_clr_q;
    logic [NUM_IR-1:0] irr_clr_d;
    logic [NUM_IR-1:0] set_mask;
    logic [NUM_IR-1:0] clr_mask;
    logic [7:0]        data_out;
    logic              data_out_en;
    logic              unused_icw2;

    assign unused_icw2 = &{1'b0, ICW2[2:0]};

    assign fall = inta_d & ~bus.INTA_n;
    assign rise = ~inta_d & bus.INTA_n;

    // Scan high to low so the lowest set index wins.
    always_comb begin
        req     = IRR & ~IMR;
        cand    = SPURIOUS_LOC;
        isr_low = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (req[i])   cand    = 3'(i);
            if (isr_q[i]) isr_low = 3'(i);
        end
        valid = (req != '0) &&
                ((isr_q == '0) || (cand < isr_low));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inta_d    <= 1'b1;
            int_q     <= 1'b0;
            loc_q     <= SPURIOUS_LOC;
            exists_q  <= 1'b0;
            isr_q     <= '0;
            irr_clr_q <= '0;
        end else begin
            state_q   <= state_d;
            inta_d    <= bus.INTA_n;
            int_q     <= int_d;
            loc_q     <= loc_d;
            exists_q  <= exists_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall) state_d = ACK1;
            ACK1:  if (rise) state_d = ACK2;
            ACK2:  if (fall) state_d = DRIVE;
            DRIVE: if (rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_d       = int_q;
        loc_d       = loc_q;
        exists_d    = exists_q;
        set_mask    = '0;
        clr_mask    = '0;
        irr_clr_d   = '0;
        data_out    = '0;
        data_out_en = 1'b0;
        if (EOI_Strobe) begin
            if (EOI_Specific)
                clr_mask = NUM_IR'(1) << EOI_Level;
            else if (isr_q != '0)
                clr_mask = NUM_IR'(1) << isr_low;
        end
        unique case (state_q)
            IDLE: begin
                int_d    = valid;
                loc_d    = cand;
                exists_d = valid;
                if (fall && valid) begin
                    set_mask  = NUM_IR'(1) << cand;
                    irr_clr_d = NUM_IR'(1) << cand;
                end else if (fall) begin
                    loc_d    = SPURIOUS_LOC;
                    exists_d = 1'b0;
                end
            end
            DRIVE: begin
                data_out    = {ICW2[7:3], loc_q};
                data_out_en = bus.Address_Write_Enable &
                              ~bus.INTA_n;
                if (rise && AEOI && exists_q)
                    clr_mask = clr_mask | (NUM_IR'(1) << loc_q);
            end
            default: ;
        endcase
        // Clear before set so a same-bit collision keeps the set.
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    assign ISR                    = isr_q;
    assign IRR_Clear              = irr_clr_q;
    assign bus.INT                = int_q;
    assign bus.Interrupt_Location = loc_q;
    assign bus.interruptExists    = exists_q;
    assign bus.Data_Out           = data_out;
    assign bus.Data_Out_En        = data_out_en;
endmodule
